// File: rtl/fifo_deq_serializer.sv
// Width down-converter: dequeues one wide word from an upstream FIFO and
// enqueues it as in_width/out_width narrow beats into a downstream FIFO.
module fifo_deq_serializer #(
   parameter int in_width  = 32,
   parameter int out_width = 8,
   parameter bit lsb_first = 1'b1
) (
   input  logic                                   CLK,
   input  logic                                   RST,
   input  logic                                   EMPTY_N,
   input  logic [in_width-1:0]                    D_OUT,
   output logic                                   DEQ,
   input  logic                                   FULL_N,
   output logic                                   ENQ,
   output logic [out_width-1:0]                   D_IN,
   input  logic                                   CLR,
   output logic                                   BUSY,
   output logic [$clog2(in_width/out_width)-1:0]  BEAT_IDX
);

   localparam int R  = in_width / out_width;
   localparam int CW = $clog2(R);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                state_reg, state_next;
   logic [in_width-1:0]   hold_reg, hold_next;
   logic [CW-1:0]         cnt_reg, cnt_next;
   logic [in_width-1:0]   hold_shift;
   logic                  last;

   // The emit end is the low slice for lsb_first, the high slice otherwise;
   // consumed beats are shifted out of that end with zero fill.
   generate
      if (lsb_first) begin : g_lsb
         assign hold_shift = hold_reg >> out_width;
         assign D_IN       = hold_reg[out_width-1:0];
      end else begin : g_msb
         assign hold_shift = hold_reg << out_width;
         assign D_IN       = hold_reg[in_width-1 -: out_width];
      end
   endgenerate

   assign BUSY     = (state_reg == SHIFT);
   assign BEAT_IDX = cnt_reg;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         hold_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         hold_reg  <= hold_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      hold_next  = hold_reg;
      last       = (state_reg == SHIFT) && (cnt_reg == CW'(R - 1));
      ENQ        = (state_reg == SHIFT) && FULL_N && !CLR && !RST;
      // Reloading on the last beat keeps the output stream gap-free.
      DEQ        = EMPTY_N && !CLR && !RST && ((state_reg == IDLE) || (last && ENQ));

      if (CLR) begin
         state_next = IDLE;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (DEQ) begin
                  hold_next  = D_OUT;
                  cnt_next   = '0;
                  state_next = SHIFT;
               end
            end
            SHIFT: begin
               if (ENQ) begin
                  if (!last) begin
                     hold_next = hold_shift;
                     cnt_next  = cnt_reg + CW'(1);
                  end else if (DEQ) begin
                     hold_next = D_OUT;
                     cnt_next  = '0;
                  end else begin
                     state_next = IDLE;
                     cnt_next   = '0;
                  end
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   always @(posedge CLK) begin
      if (DEQ && !EMPTY_N) $warning("fifo_deq_serializer: DEQ while EMPTY_N=0");
      if (ENQ && !FULL_N)  $warning("fifo_deq_serializer: ENQ while FULL_N=0");
   end
`endif

endmodule

// File: tb/tb_fifo_deq_serializer.sv
// Scoreboard bench: an LSB-first and an MSB-first serializer share one
// stimulus stream; expected beats are queued per dequeued word.
module tb_fifo_deq_serializer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        EMPTY_N = 1'b0;
   logic [31:0] D_OUT = '0;
   logic        FULL_N = 1'b0;
   logic        CLR = 1'b0;

   logic        DEQ_l, ENQ_l, BUSY_l, DEQ_m, ENQ_m, BUSY_m;
   logic [7:0]  D_IN_l, D_IN_m;
   logic [1:0]  BEAT_IDX_l, BEAT_IDX_m;

   typedef struct {
      logic [7:0] data;
      logic [1:0] idx;
   } beat_t;

   logic [31:0] src_q[$];
   beat_t       exp_l[$];
   beat_t       exp_m[$];
   int          tests = 0;
   int          fails = 0;
   bit          known = 1'b0;
   bit          hold_zero = 1'b0;

   always #5 CLK = ~CLK;

   fifo_deq_serializer #(.in_width(32), .out_width(8), .lsb_first(1'b1)) dut_l (
      .CLK(CLK), .RST(RST), .EMPTY_N(EMPTY_N), .D_OUT(D_OUT), .DEQ(DEQ_l),
      .FULL_N(FULL_N), .ENQ(ENQ_l), .D_IN(D_IN_l), .CLR(CLR), .BUSY(BUSY_l),
      .BEAT_IDX(BEAT_IDX_l)
   );

   fifo_deq_serializer #(.in_width(32), .out_width(8), .lsb_first(1'b0)) dut_m (
      .CLK(CLK), .RST(RST), .EMPTY_N(EMPTY_N), .D_OUT(D_OUT), .DEQ(DEQ_m),
      .FULL_N(FULL_N), .ENQ(ENQ_m), .D_IN(D_IN_m), .CLR(CLR), .BUSY(BUSY_m),
      .BEAT_IDX(BEAT_IDX_m)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check control outputs against the model,
   // then advance the model (word accepted => its beats join the scoreboard).
   task automatic cycle(input bit rst_i, input bit clr_i, input bit full_i, input bit gate_i);
      bit         busy, enq_e, deq_e;
      logic [1:0] idx_e;
      logic [31:0] w;
      @(negedge CLK);
      RST     = rst_i;
      CLR     = clr_i;
      FULL_N  = full_i;
      EMPTY_N = gate_i && (src_q.size() > 0);
      D_OUT   = (src_q.size() > 0) ? src_q[0] : $urandom;
      #1;
      busy  = (exp_l.size() > 0);
      idx_e = busy ? exp_l[0].idx : 2'd0;
      enq_e = busy && FULL_N && !CLR && !RST;
      deq_e = EMPTY_N && !CLR && !RST && (!busy || ((exp_l.size() == 1) && enq_e));
      check("deq_lsb", DEQ_l, deq_e);
      check("deq_msb", DEQ_m, deq_e);
      check("enq_lsb", ENQ_l, enq_e);
      check("enq_msb", ENQ_m, enq_e);
      if (known) begin
         check("busy_lsb", BUSY_l, busy);
         check("busy_msb", BUSY_m, busy);
         check("idx_lsb", BEAT_IDX_l, idx_e);
         check("idx_msb", BEAT_IDX_m, idx_e);
         if (busy) begin
            check("dcur_lsb", D_IN_l, exp_l[0].data);
            check("dcur_msb", D_IN_m, exp_m[0].data);
         end else if (hold_zero) begin
            check("dzero_lsb", D_IN_l, 8'h00);
            check("dzero_msb", D_IN_m, 8'h00);
         end
      end
      if (RST) begin
         exp_l.delete();
         exp_m.delete();
         known     = 1'b1;
         hold_zero = 1'b1;
      end else if (CLR) begin
         exp_l.delete();
         exp_m.delete();
         hold_zero = 1'b0;
      end else if (deq_e) begin
         w = src_q.pop_front();
         hold_zero = 1'b0;
         for (int k = 0; k < 4; k++) begin
            exp_l.push_back('{data: w[k*8 +: 8],       idx: 2'(k)});
            exp_m.push_back('{data: w[(3-k)*8 +: 8],   idx: 2'(k)});
         end
      end
   endtask

   task automatic run(input int n, input bit full_i);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, full_i, 1'b1);
   endtask

   // Monitor: every accepted beat must match the head of the scoreboard.
   always @(negedge CLK) begin
      beat_t e;
      #2;
      if (ENQ_l) begin
         if (exp_l.size() == 0) check("beat_lsb_unexpected", 32'd1, 32'd0);
         else begin
            e = exp_l.pop_front();
            check("beat_lsb", D_IN_l, e.data);
            check("beat_idx_lsb", BEAT_IDX_l, e.idx);
         end
      end
      if (ENQ_m) begin
         if (exp_m.size() == 0) check("beat_msb_unexpected", 32'd1, 32'd0);
         else begin
            e = exp_m.pop_front();
            check("beat_msb", D_IN_m, e.data);
            check("beat_idx_msb", BEAT_IDX_m, e.idx);
         end
      end
   end

   initial begin
      // Reset with upstream data pending and downstream ready
      src_q.push_back(32'hA1B2C3D4);
      cycle(1'b1, 1'b0, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, 1'b1);
      check("reset_dout_lsb", D_IN_l, 8'h00);
      // Single word, then idle
      run(7, 1'b1);
      // Backpressure at beat index 2
      src_q.push_back(32'hA1B2C3D4);
      run(3, 1'b1);
      run(3, 1'b0);
      run(4, 1'b1);
      // Back-to-back words
      src_q.push_back(32'h03020100);
      src_q.push_back(32'h07060504);
      run(11, 1'b1);
      // Clear after the first beat
      src_q.push_back(32'hA1B2C3D4);
      run(2, 1'b1);
      cycle(1'b0, 1'b1, 1'b1, 1'b1);
      src_q.push_back(32'h11223344);
      run(6, 1'b1);
      // Reset after the second beat
      src_q.push_back(32'hA1B2C3D4);
      run(3, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, 1'b1);
      run(3, 1'b1);
      // Randomized traffic with stalls, clears and occasional resets
      for (int i = 0; i < 3000; i++) begin
         if (($urandom_range(0, 3) != 0) && (src_q.size() < 4)) src_q.push_back($urandom);
         cycle($urandom_range(0, 149) == 0, $urandom_range(0, 49) == 0,
               $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8);
      end
      run(12, 1'b1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
